srv_line_fill: RTL and testbench

//   Responder side of the icache refill interface (ext_req/ext_rsp/ext_data).

---
 rtl/srv_line_fill.sv | 94 +++++++++
 tb/tb_srv_line_fill.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/srv_line_fill.sv
// srv_line_fill: responder side of the icache refill interface.
// Accepts a line request, reads LINE_WORDS consecutive words from a
// combinational ROM (LATENCY wait cycles before each capture) and returns
// the whole line with a single-cycle ext_rsp_o pulse.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ext_addr_i    byte address of requested line (low line bits ignored)
//   ext_req_i     refill request level, four-phase handshake
//   ext_rsp_o     one-cycle pulse, ext_data_o holds the line
//   ext_data_o    line data, word k at bits [32k+31:32k]
//   rom_addr_o    byte address presented to the ROM
//   rom_data_i    ROM read data for rom_addr_o
//   busy_o        high while a fill/response is in progress
module srv_line_fill #(
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               ext_addr_i,
    input  logic                      ext_req_i,
    output logic                      ext_rsp_o,
    output logic [32*LINE_WORDS-1:0]  ext_data_o,
    output logic [31:0]               rom_addr_o,
    input  logic [31:0]               rom_data_i,
    output logic                      busy_o
);

    localparam int              IW        = $clog2(LINE_WORDS);
    localparam logic [31:0]     LINE_MASK = 32'(4*LINE_WORDS-1);
    localparam logic [3:0]      LAT       = 4'(LATENCY);
    localparam logic [IW-1:0]   LAST      = IW'(LINE_WORDS-1);

    typedef enum logic [1:0] {IDLE, FETCH, RESP, DONE} state_t;

    state_t                       state, state_nxt;
    logic [31:0]                  base;
    logic [IW-1:0]                idx;
    logic [3:0]                   wcnt;
    logic [LINE_WORDS-1:0][31:0]  line;
    logic                         cap;

    // A word is captured once its wait countdown has expired.
    assign cap = (state == FETCH) && (wcnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ext_req_i) state_nxt = FETCH;
            FETCH:   if (cap && idx == LAST) state_nxt = RESP;
            RESP:    state_nxt = DONE;
            // Request must drop before another fill can be accepted.
            DONE:    if (!ext_req_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            idx  <= '0;
            wcnt <= '0;
            line <= '0;
        end else begin
            if (state == IDLE && ext_req_i) begin
                base <= ext_addr_i & ~LINE_MASK;
                idx  <= '0;
                wcnt <= LAT;
            end else if (state == FETCH) begin
                if (wcnt != 4'd0) begin
                    wcnt <= wcnt - 4'd1;
                end else begin
                    line[idx] <= rom_data_i;
                    wcnt      <= LAT;
                    if (idx != LAST) idx <= idx + 1'b1;
                end
            end
        end
    end

    // base/idx keep their last values outside FETCH, so the ROM address
    // naturally holds the last word fetched. base is line aligned, so the
    // add never carries out of the line.
    assign rom_addr_o = base + {{(30-IW){1'b0}}, idx, 2'b00};
    assign ext_data_o = line;
    assign ext_rsp_o  = (state == RESP);
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_srv_line_fill.sv
// Directed bench for srv_line_fill. Two instances: u0 (LATENCY=0) covers
// reset, basic fill, back-to-back, address change, wrap-around line and
// reset mid-fill; u2 (LATENCY=2) covers wait states and a held request.
// ROM model: word at byte address A holds 0x1000_0000 + A/4.
module tb_srv_line_fill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr0, addr2, rom0, rom2, rd0, rd2;
    logic         req0, req2, rsp0, rsp2, busy0, busy2;
    logic [127:0] data0, data2;
    int           n_chk = 0;
    int           n_fail = 0;
    int           n;

    always #5 clk = ~clk;

    assign rd0 = 32'h1000_0000 + (rom0 >> 2);
    assign rd2 = 32'h1000_0000 + (rom2 >> 2);

    srv_line_fill #(.LINE_WORDS(4), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .ext_addr_i(addr0), .ext_req_i(req0),
        .ext_rsp_o(rsp0), .ext_data_o(data0), .rom_addr_o(rom0),
        .rom_data_i(rd0), .busy_o(busy0));

    srv_line_fill #(.LINE_WORDS(4), .LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .ext_addr_i(addr2), .ext_req_i(req2),
        .ext_rsp_o(rsp2), .ext_data_o(data2), .rom_addr_o(rom2),
        .rom_data_i(rd2), .busy_o(busy2));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until rsp0 is seen, bounded.
    task automatic wait_rsp0(output int cnt);
        cnt = 0;
        while (rsp0 !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; addr0 = 32'h14; req2 = 1'b0; addr2 = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_rsp0",  128'(rsp0),  128'd0);
        chk("rst_data0", data0,       128'd0);
        chk("rst_rom0",  128'(rom0),  128'd0);
        chk("rst_busy0", 128'(busy0), 128'd0);
        chk("rst_busy2", 128'(busy2), 128'd0);
        chk("rst_data2", data2,       128'd0);

        // basic fill, accepted on the first edge after reset release
        rst_n = 1'b1;
        @(negedge clk);
        chk("t2_a0",   128'(rom0),  128'h10);
        chk("t2_busy", 128'(busy0), 128'd1);
        @(negedge clk);
        chk("t2_a1",   128'(rom0), 128'h14);
        chk("t2_w0",   128'(data0[31:0]), 128'h1000_0004);
        @(negedge clk);
        chk("t2_a2",   128'(rom0), 128'h18);
        @(negedge clk);
        chk("t2_a3",   128'(rom0), 128'h1C);
        chk("t2_rsp_early", 128'(rsp0), 128'd0);
        @(negedge clk);
        chk("t2_rsp",  128'(rsp0), 128'd1);
        chk("t2_line", data0, 128'h10000007_10000006_10000005_10000004);

        // back-to-back with a one-cycle low gap
        req0 = 1'b0;
        @(negedge clk);
        chk("t4_rsp_width", 128'(rsp0), 128'd0);
        @(negedge clk);
        chk("t4_idle", 128'(busy0), 128'd0);
        req0 = 1'b1; addr0 = 32'h20;
        @(negedge clk);
        chk("t4_a0",    128'(rom0), 128'h20);
        chk("t4_hold",  data0, 128'h10000007_10000006_10000005_10000004);
        @(negedge clk);
        chk("t4_first", data0, 128'h10000007_10000006_10000005_10000008);
        wait_rsp0(n);
        chk("t4_lat",  128'(n), 128'd3);
        chk("t4_line", data0, 128'h1000000B_1000000A_10000009_10000008);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // wait states and a request held after the response
        req2 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("t3_addr", 128'(rom2), 128'(32'((c-1)/3*4)));
            chk("t3_norsp", 128'(rsp2), 128'd0);
        end
        @(negedge clk);
        chk("t3_rsp",  128'(rsp2), 128'd1);
        chk("t3_line", data2, 128'h10000003_10000002_10000001_10000000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_no2nd", 128'(rsp2),  128'd0);
            chk("t3_busy",  128'(busy2), 128'd1);
        end
        req2 = 1'b0;
        @(negedge clk);
        chk("t3_idle", 128'(busy2), 128'd0);

        // address change and request drop during FETCH
        addr0 = 32'h40; req0 = 1'b1;
        @(negedge clk);
        chk("t5_a0", 128'(rom0), 128'h40);
        addr0 = 32'h80;
        @(negedge clk);
        req0 = 1'b0;
        wait_rsp0(n);
        chk("t5_lat",  128'(n), 128'd3);
        chk("t5_line", data0, 128'h10000013_10000012_10000011_10000010);
        @(negedge clk);
        chk("t5_done", 128'(busy0), 128'd1);
        @(negedge clk);
        chk("t5_idle", 128'(busy0), 128'd0);

        // top-of-memory line: no carry out of the line
        addr0 = 32'hFFFF_FFF7; req0 = 1'b1;
        @(negedge clk); chk("wr_a0", 128'(rom0), 128'hFFFF_FFF0);
        @(negedge clk); chk("wr_a1", 128'(rom0), 128'hFFFF_FFF4);
        @(negedge clk); chk("wr_a2", 128'(rom0), 128'hFFFF_FFF8);
        @(negedge clk); chk("wr_a3", 128'(rom0), 128'hFFFF_FFFC);
        wait_rsp0(n);
        chk("wr_lat",  128'(n), 128'd1);
        chk("wr_line", data0, 128'h4FFFFFFF_4FFFFFFE_4FFFFFFD_4FFFFFFC);
        chk("wr_hold", 128'(rom0), 128'hFFFF_FFFC);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // reset during the third word
        addr0 = 32'h80; req0 = 1'b1;
        @(negedge clk); chk("t6_a0", 128'(rom0), 128'h80);
        @(negedge clk);
        @(negedge clk); chk("t6_a2", 128'(rom0), 128'h88);
        rst_n = 1'b0; req0 = 1'b0;
        #1;
        chk("t6_data", data0,       128'd0);
        chk("t6_rsp",  128'(rsp0),  128'd0);
        chk("t6_busy", 128'(busy0), 128'd0);
        chk("t6_rom",  128'(rom0),  128'd0);
        @(negedge clk);
        chk("t6_rsp_rst", 128'(rsp0), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rsp_rel",  128'(rsp0),  128'd0);
        chk("t6_idle_rel", 128'(busy0), 128'd0);
        addr0 = 32'h40; req0 = 1'b1;
        wait_rsp0(n);
        chk("t6_lat",  128'(n), 128'd5);
        chk("t6_line", data0, 128'h10000013_10000012_10000011_10000010);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
